// File: rtl/data_ram_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the data RAM responder: read/write request codes,
// responder state encoding and the default geometry of the RAM.
// ---------------------------------------------------------------------------
package data_ram_pkg;

   localparam int DEF_ADDR_W      = 4;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_WAIT_STATES = 1;

   // Request codes driven by the memory controller on i_RW
   localparam logic [1:0] RW_IDLE = 2'b00;
   localparam logic [1:0] RW_LDR  = 2'b01;
   localparam logic [1:0] RW_STR  = 2'b10;
   localparam logic [1:0] RW_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_ram_array.sv
// ---------------------------------------------------------------------------
// data_ram_array
// Storage for the data RAM: 2**ADDR_W words of DATA_W bits, zeroed on reset,
// synchronous write and registered read. The read register is the load-data
// output of the responder and holds its value until the next read.
//
// Optional feature (macro DATA_RAM_PARITY_EN): one even-parity bit per word,
// written alongside the data (inverted when i_par_inject is set) and checked
// on every read; o_parerr pulses in the cycle the read data appears.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_we             write i_wdata to i_addr at this edge
//   i_re             load mem[i_addr] into o_rdata at this edge
//   i_addr, i_wdata  access address and write data
//   o_rdata          registered read data
//   i_par_inject     (macro only) flip the stored parity bit on this write
//   o_parerr         (macro only) parity mismatch on the read just performed
// ---------------------------------------------------------------------------
module data_ram_array
   import data_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
`ifdef DATA_RAM_PARITY_EN
   ,
   input  logic              i_par_inject,
   output logic              o_parerr
`endif
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the storage is reset word by word because zeroed contents after
   // reset are architecturally visible; this keeps it in flops, not an SRAM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         o_rdata <= '0;
      end else begin
         if (i_we) begin
            mem[i_addr] <= i_wdata;
         end
         if (i_re) begin
            o_rdata <= mem[i_addr];
         end
      end
   end

`ifdef DATA_RAM_PARITY_EN
   // Parity bit makes the XOR over data+parity zero; all-zero reset is consistent.
   logic [DEPTH-1:0] par;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         par      <= '0;
         o_parerr <= 1'b0;
      end else begin
         o_parerr <= 1'b0;
         if (i_we) begin
            par[i_addr] <= (^i_wdata) ^ i_par_inject;
         end
         if (i_re) begin
            o_parerr <= (^mem[i_addr]) != par[i_addr];
         end
      end
   end
`endif

endmodule

// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
// Memory-side responder for the CPU load/store path. Accepts a 2-bit
// read/write code from the memory controller, waits WAIT_STATES cycles,
// performs the access on a 2**ADDR_W x DATA_W RAM and pulses o_ready.
// A request level held by the controller is serviced once: a new request is
// accepted only after i_RW == 00 has been sampled (the rearm flag).
//
// Optional feature (macro DATA_RAM_PARITY_EN): per-word parity with an
// injection input and a parity-error output.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_RW             00 idle, 01 load, 10 store, 11 illegal
//   i_ramaddr        word address
//   i_databus        store data
//   o_databus        load data (holds last read value)
//   o_ready          one-cycle completion pulse
//   o_busy           high from the cycle after accept through the o_ready cycle
//   o_err            one-cycle pulse after an illegal code is sampled
//   i_par_inject     (macro only) corrupt the stored parity bit on a write
//   o_parerr         (macro only) parity mismatch, pulses with o_ready
// ---------------------------------------------------------------------------
module data_ram_responder
   import data_ram_pkg::*;
#(
   parameter int WAIT_STATES = DEF_WAIT_STATES,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_RW,
   input  logic [ADDR_W-1:0] i_ramaddr,
   input  logic [DATA_W-1:0] i_databus,
   output logic [DATA_W-1:0] o_databus,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_err
`ifdef DATA_RAM_PARITY_EN
   ,
   input  logic              i_par_inject,
   output logic              o_parerr
`endif
);

   // Counter start value; unused when WAIT_STATES == 0 (accept goes straight to RESP)
   localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              rearm_q, rearm_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ready_d, busy_d, err_d;

   // Array access strobe, issued on the edge that enters RESP
   logic              acc_we, acc_re;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

`ifdef DATA_RAM_PARITY_EN
   logic              inj_q, inj_d;
   logic              acc_inj;
`endif

   // NOTE: every signal written here gets a default first, so no latch is
   // inferred on paths that leave it untouched.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rearm_d   = rearm_q;
      op_d      = op_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ready_d   = 1'b0;
      busy_d    = o_busy;
      err_d     = 1'b0;
      acc_we    = 1'b0;
      acc_re    = 1'b0;
      acc_addr  = addr_q;
      acc_wdata = data_q;
`ifdef DATA_RAM_PARITY_EN
      inj_d     = inj_q;
      acc_inj   = inj_q;
`endif

      // Rearm tracks the idle code in every state; accept/illegal clear it below.
      if (i_RW == RW_IDLE) begin
         rearm_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rearm_q && (i_RW == RW_LDR || i_RW == RW_STR)) begin
               rearm_d = 1'b0;
               op_d    = i_RW;
               addr_d  = i_ramaddr;
               data_d  = i_databus;
               busy_d  = 1'b1;
`ifdef DATA_RAM_PARITY_EN
               inj_d   = i_par_inject;
`endif
               if (WAIT_STATES == 0) begin
                  // Zero wait states: the accept edge is also the access edge,
                  // so the request is taken straight from the inputs.
                  state_d   = RESP;
                  ready_d   = 1'b1;
                  acc_we    = (i_RW == RW_STR);
                  acc_re    = (i_RW == RW_LDR);
                  acc_addr  = i_ramaddr;
                  acc_wdata = i_databus;
`ifdef DATA_RAM_PARITY_EN
                  acc_inj   = i_par_inject;
`endif
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else if (rearm_q && i_RW == RW_ILL) begin
               rearm_d = 1'b0;
               err_d   = 1'b1;
            end
         end

         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
               ready_d = 1'b1;
               acc_we  = (op_q == RW_STR);
               acc_re  = (op_q == RW_LDR);
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values computed before the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         rearm_q <= 1'b1;
         op_q    <= RW_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         o_ready <= 1'b0;
         o_busy  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rearm_q <= rearm_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         o_ready <= ready_d;
         o_busy  <= busy_d;
         o_err   <= err_d;
      end
   end

`ifdef DATA_RAM_PARITY_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inj_q <= 1'b0;
      end else begin
         inj_q <= inj_d;
      end
   end
`endif

   data_ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_we         (acc_we),
      .i_re         (acc_re),
      .i_addr       (acc_addr),
      .i_wdata      (acc_wdata),
      .o_rdata      (o_databus)
`ifdef DATA_RAM_PARITY_EN
      ,
      .i_par_inject (acc_inj),
      .o_parerr     (o_parerr)
`endif
   );

endmodule

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
// Three responders with WAIT_STATES = 0, 1 and 7 share clock and reset but
// have their own request inputs. A directed table covers the documented
// scenarios, hand-written sequences cover the illegal code and a reset in the
// middle of a store, and a randomized phase is checked against a word-array
// model of the RAM (plus last-read register and parity-corruption flags).
// Parity checks are active when DATA_RAM_PARITY_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_ram_responder;
   import data_ram_pkg::*;

   localparam int N_INST = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rw     [N_INST];
   logic [3:0]  addr   [N_INST];
   logic [31:0] wdata  [N_INST];
   logic [31:0] rdata  [N_INST];
   logic        ready  [N_INST];
   logic        busy   [N_INST];
   logic        err    [N_INST];
   logic        inj    [N_INST];
`ifdef DATA_RAM_PARITY_EN
   logic        parerr [N_INST];
`endif

   for (genvar g = 0; g < N_INST; g++) begin : g_dut
      data_ram_responder #(
         .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 7)),
         .ADDR_W      (4),
         .DATA_W      (32)
      ) u_dut (
         .i_clk        (clk),
         .i_rst_n      (rst_n),
         .i_RW         (rw[g]),
         .i_ramaddr    (addr[g]),
         .i_databus    (wdata[g]),
         .o_databus    (rdata[g]),
         .o_ready      (ready[g]),
         .o_busy       (busy[g]),
         .o_err        (err[g])
`ifdef DATA_RAM_PARITY_EN
         ,
         .i_par_inject (inj[g]),
         .o_parerr     (parerr[g])
`endif
      );
   end

   // Reference model: RAM contents, last value read, corrupted-parity flags
   logic [31:0] mdl_mem  [N_INST][16];
   logic [31:0] mdl_last [N_INST];
   bit          mdl_bad  [N_INST][16];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int          k;
      logic [1:0]  op;
      logic [3:0]  a;
      logic [31:0] d;
      bit          hold;
      bit          scr;
      bit          inj;
      logic [31:0] exp_db;
   } vec_t;

   vec_t tab[$];

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 1 : 7);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_INST; k++) begin
         mdl_last[k] = '0;
         for (int i = 0; i < 16; i++) begin
            mdl_mem[k][i] = '0;
            mdl_bad[k][i] = 1'b0;
         end
      end
   endtask

   task automatic add(input int k, input logic [1:0] op, input logic [3:0] a,
                      input logic [31:0] d, input bit hold, input bit scr,
                      input bit pinj, input logic [31:0] exp_db);
      vec_t v;
      v.k = k; v.op = op; v.a = a; v.d = d;
      v.hold = hold; v.scr = scr; v.inj = pinj; v.exp_db = exp_db;
      tab.push_back(v);
   endtask

   // One complete access on instance k, starting at a negedge. Observes a
   // fixed window of WS+3 cycles after the accept edge, then drops i_RW to 00
   // for one edge so the next request is rearmed.
   task automatic txn(input int k, input logic [1:0] op, input logic [3:0] a,
                      input logic [31:0] d, input bit hold, input bit scr,
                      input bit pinj, input logic [31:0] exp_db);
      int          ws;
      int          rdy_cnt;
      int          busy_cnt;
      int          err_cnt;
      int          rdy_at;
      int          pe_cnt;
      bit          exp_pe;
      logic [31:0] db_at;
      ws = ws_of(k);
      rdy_cnt = 0; busy_cnt = 0; err_cnt = 0; rdy_at = -1; pe_cnt = 0;
      db_at = '0;
      rw[k] = op; addr[k] = a; wdata[k] = d; inj[k] = pinj;
      for (int c = 1; c <= ws + 3; c++) begin
         @(negedge clk);
         if (ready[k]) begin
            rdy_cnt++;
            if (rdy_at < 0) begin
               rdy_at = c;
               db_at  = rdata[k];
            end
         end
         if (busy[k]) busy_cnt++;
         if (err[k])  err_cnt++;
`ifdef DATA_RAM_PARITY_EN
         if (parerr[k]) pe_cnt += ready[k] ? 1 : 100;
`endif
         if (c == 1 && !hold) rw[k] = RW_IDLE;
         if (scr) begin
            addr[k]  = 4'($urandom);
            wdata[k] = $urandom;
            inj[k]   = 1'($urandom);
         end
      end
      rw[k] = RW_IDLE;
      inj[k] = 1'b0;
      @(negedge clk);

      check($sformatf("ready_latency i%0d op%0d a%0d", k, op, a), 32'(rdy_at), 32'(ws + 1));
      check($sformatf("ready_count i%0d op%0d a%0d", k, op, a), 32'(rdy_cnt), 32'd1);
      check($sformatf("busy_cycles i%0d op%0d a%0d", k, op, a), 32'(busy_cnt), 32'(ws + 1));
      check($sformatf("err_quiet i%0d op%0d a%0d", k, op, a), 32'(err_cnt), 32'd0);
      check($sformatf("databus i%0d op%0d a%0d", k, op, a), db_at, exp_db);
      exp_pe = (op == RW_LDR) && mdl_bad[k][a];
`ifdef DATA_RAM_PARITY_EN
      check($sformatf("parerr i%0d op%0d a%0d", k, op, a), 32'(pe_cnt), 32'(exp_pe));
`endif

      if (op == RW_STR) begin
         mdl_mem[k][a] = d;
`ifdef DATA_RAM_PARITY_EN
         mdl_bad[k][a] = pinj;
`endif
      end else begin
         mdl_last[k] = mdl_mem[k][a];
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int k = 0; k < N_INST; k++) begin
         check($sformatf("%s ready i%0d", tag, k), 32'(ready[k]), 32'd0);
         check($sformatf("%s busy i%0d", tag, k), 32'(busy[k]), 32'd0);
         check($sformatf("%s err i%0d", tag, k), 32'(err[k]), 32'd0);
         check($sformatf("%s databus i%0d", tag, k), rdata[k], 32'd0);
      end
   endtask

   initial begin
      for (int k = 0; k < N_INST; k++) begin
         rw[k] = RW_IDLE; addr[k] = '0; wdata[k] = '0; inj[k] = 1'b0;
      end
      model_reset();

      // Directed table (all RAMs zero after reset)
      add(1, RW_STR, 4'd3,  32'hDEADBEEF, 1, 0, 0, 32'h0);
      add(1, RW_LDR, 4'd3,  32'h0,        0, 0, 0, 32'hDEADBEEF);
      add(0, RW_LDR, 4'd15, 32'h0,        0, 0, 0, 32'h0);
      add(2, RW_LDR, 4'd15, 32'h0,        0, 0, 0, 32'h0);
      add(1, RW_STR, 4'd5,  32'h00001234, 1, 1, 0, 32'hDEADBEEF);
      add(1, RW_LDR, 4'd5,  32'h0,        0, 0, 0, 32'h00001234);
      add(1, RW_LDR, 4'd4,  32'h0,        0, 0, 0, 32'h0);
      add(1, RW_LDR, 4'd6,  32'h0,        0, 0, 0, 32'h0);
      add(0, RW_STR, 4'd9,  32'hA5A5A5A5, 1, 0, 0, 32'h0);
      add(0, RW_LDR, 4'd9,  32'h0,        1, 0, 0, 32'hA5A5A5A5);
      add(2, RW_STR, 4'd0,  32'hCAFEF00D, 0, 1, 0, 32'h0);
      add(2, RW_LDR, 4'd0,  32'h0,        0, 0, 0, 32'hCAFEF00D);
      add(1, RW_STR, 4'd2,  32'h0F0F0F0F, 0, 0, 1, 32'h0);
      add(1, RW_LDR, 4'd2,  32'h0,        0, 0, 0, 32'h0F0F0F0F);
      add(1, RW_STR, 4'd4,  32'h13579BDF, 0, 0, 0, 32'h0F0F0F0F);
      add(1, RW_LDR, 4'd4,  32'h0,        0, 0, 0, 32'h13579BDF);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");

      foreach (tab[i]) begin
         txn(tab[i].k, tab[i].op, tab[i].a, tab[i].d, tab[i].hold, tab[i].scr,
             tab[i].inj, tab[i].exp_db);
      end

      // Illegal code held for two edges: one err pulse, no busy, then normal service
      rw[1] = RW_ILL;
      @(negedge clk);
      check("illegal err_pulse", 32'(err[1]), 32'd1);
      check("illegal busy", 32'(busy[1]), 32'd0);
      check("illegal ready", 32'(ready[1]), 32'd0);
      @(negedge clk);
      check("illegal err_single", 32'(err[1]), 32'd0);
      check("illegal busy_after", 32'(busy[1]), 32'd0);
      rw[1] = RW_IDLE;
      @(negedge clk);
      txn(1, RW_LDR, 4'd3, 32'h0, 0, 0, 0, 32'hDEADBEEF);

      // Reset during the wait state of a store: no completion, store lost
      rw[1] = RW_STR; addr[1] = 4'd7; wdata[1] = 32'h0000FFFF;
      @(negedge clk);
      check("abort busy_before_reset", 32'(busy[1]), 32'd1);
      rst_n = 1'b0;
      rw[1] = RW_IDLE;
      @(negedge clk);
      check("abort ready_in_reset", 32'(ready[1]), 32'd0);
      check("abort busy_in_reset", 32'(busy[1]), 32'd0);
      rst_n = 1'b1;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check("abort ready_after_reset", 32'(ready[1]), 32'd0);
      end
      check_idle_outputs("post_abort");
      txn(1, RW_LDR, 4'd7, 32'h0, 0, 0, 0, 32'h0);
      txn(1, RW_LDR, 4'd3, 32'h0, 0, 0, 0, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         int          k;
         logic [1:0]  op;
         logic [3:0]  a;
         logic [31:0] d;
         logic [31:0] exp_db;
         k  = int'($urandom_range(0, N_INST - 1));
         op = ($urandom_range(0, 1) == 1) ? RW_LDR : RW_STR;
         a  = 4'($urandom);
         d  = $urandom;
         exp_db = (op == RW_LDR) ? mdl_mem[k][a] : mdl_last[k];
         txn(k, op, a, d, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), exp_db);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
